// File: rtl/plot_port_arbiter.sv
// Shares the single VGA plot port among N_REQ pixel producers. Requester 0 has absolute priority;
// the rest are served round-robin. Grants last a whole burst, with forced release after MAX_HOLD cycles.
module plot_port_arbiter #(
  parameter int N_REQ    = 4,
  parameter int XW       = 10,
  parameter int CW       = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int MAX_HOLD = 4096
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ-1:0]    i_done,
  input  logic [N_REQ-1:0]    i_pix_en,
  input  logic [N_REQ*XW-1:0] i_pix_x,
  input  logic [N_REQ*XW-1:0] i_pix_y,
  input  logic [N_REQ*CW-1:0] i_pix_colour,
  output logic [N_REQ-1:0]    o_gnt,
  output logic                o_busy,
  output logic [XW-1:0]       o_vga_x,
  output logic [XW-1:0]       o_vga_y,
  output logic [CW-1:0]       o_vga_colour,
  output logic                o_vga_plot,
  output logic                o_timeout_flag,
  output logic [1:0]          o_timeout_id
);

  localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IW-1:0]    r_gidx;
  logic [IW-1:0]    r_ptr;
  logic [HW-1:0]    r_hold;
  logic             r_busy;
  logic [XW-1:0]    r_vga_x;
  logic [XW-1:0]    r_vga_y;
  logic [CW-1:0]    r_vga_colour;
  logic             r_vga_plot;
  logic             r_to_flag;
  logic [1:0]       r_to_id;

  logic             w_found;
  logic             w_hit;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_idx;
  logic [XW-1:0]    w_sel_x;
  logic [XW-1:0]    w_sel_y;
  logic [CW-1:0]    w_sel_colour;
  logic             w_sel_en;
  logic             w_in_range;
  logic             w_end;
  logic             w_timeout;

  // Pick the winner: requester 0 outright, else first active requester at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    if (i_req[0]) begin
      w_found = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ - 1; k++) begin
        w_idx   = IW'(((int'(r_ptr) - 1 + k) % (N_REQ - 1)) + 1);
        w_hit   = !w_found && i_req[w_idx];
        w_win   = w_hit ? w_idx : w_win;
        w_found = w_found | w_hit;
      end
    end
  end

  assign w_sel_x      = i_pix_x[int'(r_gidx)*XW +: XW];
  assign w_sel_y      = i_pix_y[int'(r_gidx)*XW +: XW];
  assign w_sel_colour = i_pix_colour[int'(r_gidx)*CW +: CW];
  assign w_sel_en     = i_pix_en[r_gidx];
  assign w_in_range   = (w_sel_x <= XW'(X_MAX)) && (w_sel_y <= XW'(Y_MAX));
  // A dropped request ends the burst just like done, and both outrank the timeout.
  assign w_end        = i_done[r_gidx] | ~i_req[r_gidx];
  assign w_timeout    = (r_hold == HW'(MAX_HOLD - 1));

  // Grant FSM: arbitration, burst hold, forced release and the one-cycle bus gap.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_gidx    <= '0;
      r_ptr     <= IW'(1);
      r_hold    <= '0;
      r_busy    <= 1'b0;
      r_to_flag <= 1'b0;
      r_to_id   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= N_REQ'(1) << w_win;
            r_gidx  <= w_win;
            r_busy  <= 1'b1;
            r_hold  <= '0;
            if (w_win == IW'(0)) begin
              r_ptr <= r_ptr;
            end else if (w_win == IW'(N_REQ - 1)) begin
              r_ptr <= IW'(1);
            end else begin
              r_ptr <= w_win + IW'(1);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          r_hold <= r_hold + HW'(1);
          if (w_end) begin
            r_state <= S_RELEASE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_timeout) begin
            r_state   <= S_RELEASE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_to_flag <= 1'b1;
            r_to_id   <= 2'(r_gidx);
          end else begin
            r_state <= S_GRANT;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel pipeline stage: forward the granted requester's in-range pixels, hold coords otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else if ((r_state == S_GRANT) && w_sel_en && w_in_range) begin
      r_vga_x      <= w_sel_x;
      r_vga_y      <= w_sel_y;
      r_vga_colour <= w_sel_colour;
      r_vga_plot   <= 1'b1;
    end else begin
      r_vga_plot   <= 1'b0;
    end
  end

  assign o_gnt          = r_gnt;
  assign o_busy         = r_busy;
  assign o_vga_x        = r_vga_x;
  assign o_vga_y        = r_vga_y;
  assign o_vga_colour   = r_vga_colour;
  assign o_vga_plot     = r_vga_plot;
  assign o_timeout_flag = r_to_flag;
  assign o_timeout_id   = r_to_id;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Bench for plot_port_arbiter: directed scenarios plus random traffic, every cycle compared
// against a behavioural model tracking owner, bus gap, pointer and hold time as plain integers.
module tb_plot_port_arbiter;

  localparam int N        = 4;
  localparam int XW       = 10;
  localparam int CW       = 3;
  localparam int MAX_HOLD = 4096;

  logic            CLOCK_50 = 1'b0;
  logic            resetn;
  logic [N-1:0]    req, done, pix_en;
  logic [N*XW-1:0] pix_x, pix_y;
  logic [N*CW-1:0] pix_colour;
  logic [N-1:0]    o_gnt;
  logic            o_busy, o_vga_plot, o_timeout_flag;
  logic [XW-1:0]   o_vga_x, o_vga_y;
  logic [CW-1:0]   o_vga_colour;
  logic [1:0]      o_timeout_id;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int            m_owner, m_gap, m_ptr, m_hold;
  logic          e_plot, e_flag;
  logic [XW-1:0] e_x, e_y;
  logic [CW-1:0] e_col;
  logic [1:0]    e_id;

  plot_port_arbiter dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .i_req(req), .i_done(done), .i_pix_en(pix_en),
    .i_pix_x(pix_x), .i_pix_y(pix_y), .i_pix_colour(pix_colour),
    .o_gnt(o_gnt), .o_busy(o_busy),
    .o_vga_x(o_vga_x), .o_vga_y(o_vga_y), .o_vga_colour(o_vga_colour),
    .o_vga_plot(o_vga_plot), .o_timeout_flag(o_timeout_flag), .o_timeout_id(o_timeout_id)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Urgent requester first, else the active requester closest at/after the pointer.
  function automatic int pick();
    int best, bestd, d;
    best = -1; bestd = 99;
    if (req[0]) return 0;
    for (int i = 1; i < N; i++) begin
      d = (i - m_ptr + (N - 1)) % (N - 1);
      if (req[i] && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  task automatic model_edge();
    int w, x, y;
    if (!resetn) begin
      m_owner = -1; m_gap = 0; m_ptr = 1; m_hold = 0;
      e_plot = 1'b0; e_x = '0; e_y = '0; e_col = '0; e_flag = 1'b0; e_id = 2'b00;
      return;
    end
    e_plot = 1'b0;
    if (m_owner >= 0 && pix_en[m_owner]) begin
      x = int'(pix_x[m_owner*XW +: XW]);
      y = int'(pix_y[m_owner*XW +: XW]);
      if (x <= 159 && y <= 119) begin
        e_plot = 1'b1; e_x = XW'(x); e_y = XW'(y); e_col = pix_colour[m_owner*CW +: CW];
      end
    end
    if (m_owner >= 0) begin
      if (done[m_owner] || !req[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (m_hold == MAX_HOLD - 1) begin
        e_flag = 1'b1; e_id = 2'(m_owner); m_owner = -1; m_gap = 1;
      end else begin
        m_hold++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      w = pick();
      if (w >= 0) begin
        m_owner = w; m_hold = 0;
        if (w != 0) m_ptr = (w == N - 1) ? 1 : w + 1;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] e_gnt;
    @(posedge CLOCK_50);
    model_edge();
    #1;
    e_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    check_eq("gnt", o_gnt, e_gnt);
    check_eq("busy", o_busy, m_owner >= 0);
    check_eq("plot", o_vga_plot, e_plot);
    check_eq("vga_x", o_vga_x, e_x);
    check_eq("vga_y", o_vga_y, e_y);
    check_eq("colour", o_vga_colour, e_col);
    check_eq("to_flag", o_timeout_flag, e_flag);
    check_eq("to_id", o_timeout_id, e_id);
    done   = '0;
    pix_en = '0;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c);
    pix_en[i] = 1'b1;
    pix_x[i*XW +: XW] = XW'(x);
    pix_y[i*XW +: XW] = XW'(y);
    pix_colour[i*CW +: CW] = CW'(c);
  endtask

  task automatic wait_grant();
    for (int k = 0; k < 10 && o_gnt == '0; k++) step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
  endtask

  task automatic run_burst(input int idx, input logic keep, input logic raise0);
    wait_grant();
    check_eq("rr_order", o_gnt, 32'(1) << idx);
    if (raise0) req[0] = 1'b1;
    set_pix(idx, 10 + idx, 20, idx);
    done[idx] = 1'b1;
    req[idx]  = keep;
    step();
  endtask

  initial begin
    int cnt;
    resetn = 1'b0; req = 4'b1111; done = '0; pix_en = '0;
    pix_x = '0; pix_y = '0; pix_colour = '0;
    m_owner = -1; m_gap = 0; m_ptr = 1; m_hold = 0;
    e_plot = 1'b0; e_x = '0; e_y = '0; e_col = '0; e_flag = 1'b0; e_id = 2'b00;

    // reset with all requests raised
    step(); step();
    check_eq("rst_gnt", o_gnt, 4'b0000);
    check_eq("rst_plot", o_vga_plot, 1'b0);
    req = '0; resetn = 1'b1;
    step();

    // single burst from requester 2
    req = 4'b0100;
    step();
    check_eq("sb_gnt", o_gnt, 4'b0100);
    set_pix(2, 5, 6, 4); step();
    check_eq("sb_x0", o_vga_x, 10'd5);
    set_pix(2, 6, 6, 4); step();
    set_pix(2, 7, 6, 4); done[2] = 1'b1; step();
    check_eq("sb_x2", o_vga_x, 10'd7);
    check_eq("sb_end", o_gnt, 4'b0000);
    req = '0; step(); step();

    // round robin, then urgent requester slipped in during grant 2
    do_reset();
    req = 4'b1110;
    run_burst(1, 1'b1, 1'b0);
    run_burst(2, 1'b1, 1'b0);
    run_burst(3, 1'b1, 1'b0);
    run_burst(1, 1'b1, 1'b0);
    run_burst(2, 1'b1, 1'b1);
    run_burst(0, 1'b0, 1'b0);
    run_burst(3, 1'b1, 1'b0);
    req = '0; step(); step(); step();

    // clipping
    req = 4'b0010; wait_grant();
    set_pix(1, 160, 10, 5); step();
    check_eq("clip_plot0", o_vga_plot, 1'b0);
    set_pix(1, 159, 119, 5); step();
    check_eq("clip_plot1", o_vga_plot, 1'b1);
    check_eq("clip_x", o_vga_x, 10'd159);
    check_eq("clip_y", o_vga_y, 10'd119);
    done[1] = 1'b1; req = '0; step(); step(); step();

    // timeout on requester 3, requester 1 pending
    req = 4'b1000; wait_grant();
    check_eq("to_gnt", o_gnt, 4'b1000);
    req[1] = 1'b1;
    cnt = 1;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (o_gnt[3]) cnt++;
      else break;
    end
    check_eq("to_len", cnt, MAX_HOLD);
    check_eq("to_flag_set", o_timeout_flag, 1'b1);
    check_eq("to_id_val", o_timeout_id, 2'd3);
    req[3] = 1'b0;
    step();
    check_eq("to_gap", o_gnt, 4'b0000);
    step();
    check_eq("to_next", o_gnt, 4'b0010);
    done[1] = 1'b1; req = '0; step(); step(); step();

    // reset in the middle of a burst
    req = 4'b0010; wait_grant();
    set_pix(1, 3, 3, 1); resetn = 1'b0;
    step();
    check_eq("mr_plot", o_vga_plot, 1'b0);
    check_eq("mr_gnt", o_gnt, 4'b0000);
    step();
    resetn = 1'b1; req = 4'b0110;
    wait_grant();
    check_eq("mr_first", o_gnt, 4'b0010);
    done[1] = 1'b1; req = '0; step(); step(); step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
        if ($urandom_range(0, 2) == 0)
          set_pix(i, int'($urandom_range(0, 200)), int'($urandom_range(0, 150)), int'($urandom_range(0, 7)));
        if (i == m_owner) begin
          if ($urandom_range(0, 5) == 0) begin
            done[i] = 1'b1;
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          done[i] = 1'b1;
        end
      end
      step();
    end
    resetn = 1'b1; req = '0;
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
